// File: rtl/uart_rx_frame.sv
// Serial frame receiver: start, size data bits LSB first, even parity, then idle/stop; one bit per CLK_Baudin.
// Latency: DoneRx/DataOut update on the edge after the parity sample; Flag_out is combinational in the parity cycle.
// Backpressure: none on the output side; a parity failure raises Flag_out so the transmitter retransmits. Build macro: UART_RX_ERRCNT_EN adds ErrCount.
module uart_rx_frame #(
    parameter int size = 32
) (
    input  logic            CLK_Baudin,
    input  logic            RstTx,
    input  logic            RxSerialData,
    output logic [size-1:0] DataOut,
    output logic            DoneRx,
    output logic            Flag_out,
    output logic            ParityErr
`ifdef UART_RX_ERRCNT_EN
    ,
    output logic [7:0]      ErrCount
`endif
);

    // Counter must hold 0..size-1 without wrapping inside a frame.
    localparam int CW = $clog2(size) + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DATA      = 2'd1,
        S_PARITY    = 2'd2,
        S_WAIT_HIGH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [size-1:0]   shift_q, shift_d;
    logic              acc_q, acc_d;
    logic [size-1:0]   data_q, data_d;
    logic              done_q, done_d;
    logic              perr_q, perr_d;
    logic              par_mismatch;
`ifdef UART_RX_ERRCNT_EN
    logic [7:0]        errcnt_q, errcnt_d;
`endif

    // Parity of the received data bits XOR the parity bit currently on the line.
    assign par_mismatch = RxSerialData ^ acc_q;

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge CLK_Baudin or posedge RstTx) begin
        if (RstTx) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            acc_q    <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            perr_q   <= 1'b0;
`ifdef UART_RX_ERRCNT_EN
            errcnt_q <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            data_q   <= data_d;
            done_q   <= done_d;
            perr_q   <= perr_d;
`ifdef UART_RX_ERRCNT_EN
            errcnt_q <= errcnt_d;
`endif
        end
    end

    // Next-state logic: frame sequencing, shift/parity accumulation and the parity verdict.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        data_d   = data_q;
        done_d   = 1'b0;
        perr_d   = perr_q;
        Flag_out = 1'b0;
`ifdef UART_RX_ERRCNT_EN
        errcnt_d = errcnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // Any low sample counts as a start bit; there is no glitch filtering.
                if (!RxSerialData) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
            end
            S_DATA: begin
                shift_d = {RxSerialData, shift_q[size-1:1]};
                acc_d   = acc_q ^ RxSerialData;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(size - 1)) begin
                    state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                // Flag is live for the whole cycle so the transmitter samples it on this edge.
                Flag_out = par_mismatch;
                if (par_mismatch) begin
                    perr_d = 1'b1;
`ifdef UART_RX_ERRCNT_EN
                    if (errcnt_q != 8'hFF) begin
                        errcnt_d = errcnt_q + 8'd1;
                    end
`endif
                end else begin
                    data_d = shift_q;
                    done_d = 1'b1;
                    perr_d = 1'b0;
                end
                state_d = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                // The transmitter may hold the parity level before retransmitting; wait for idle.
                if (RxSerialData) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign DataOut   = data_q;
    assign DoneRx    = done_q;
    assign ParityErr = perr_q;
`ifdef UART_RX_ERRCNT_EN
    assign ErrCount  = errcnt_q;
`endif

endmodule
